// File: rtl/sequence_generator.sv
// rtl/sequence_generator.sv - serial bit-pattern transmitter feeding the pattern detector
//
// Loads a 1..PAT_W bit pattern on start and shifts it out MSB-first, one bit
// per bit_en tick, optionally repeating it with a one-bit idle gap between
// passes.
//
// Ports:
//   clock       single clock, rising edge
//   reset       synchronous, active-high
//   start       level-sampled transfer request, honoured only in IDLE
//   abort       synchronous cancel back to IDLE, no done pulse
//   bit_en      bit-rate tick; every SEND/GAP/DONE step waits for it
//   pattern     bits to send; pattern[len-1:0], bit len-1 first
//   length      bit count; 0 or >PAT_W means PAT_W
//   repeats     pass count; 0 means 1
//   serial_out  registered serial bit (detector input w)
//   bit_strobe  one-clock pulse whenever serial_out takes a pattern bit
//   busy        high in SEND, GAP and DONE
//   done        one-clock pulse after the final pass
//   state       current state encoding for LED display

module sequence_generator #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             bit_en,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] length,
  input  logic [CNT_W-1:0] repeats,
  output logic             serial_out,
  output logic             bit_strobe,
  output logic             busy,
  output logic             done,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    IDLE = 3'b000,
    SEND = 3'b001,
    GAP  = 3'b010,
    DONE = 3'b011
  } state_t;

  localparam logic [CNT_W-1:0] FULL_LEN = CNT_W'(PAT_W);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q, state_n;
  logic [PAT_W-1:0] shreg_q, shreg_n;     // bits still to send, next bit at MSB
  logic [PAT_W-1:0] pat_q, pat_n;         // left-aligned copy used to reload each pass
  logic [CNT_W-1:0] len_q, len_n;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_n;
  logic [CNT_W-1:0] pass_cnt_q, pass_cnt_n;
  logic             serial_q, serial_n;
  logic             strobe_q, strobe_n;
  logic             done_q, done_n;

  logic [CNT_W-1:0] len_clamp;
  logic [CNT_W-1:0] rep_clamp;
  logic [PAT_W-1:0] aligned;
  int               shift_amt;

  // Clamp the request fields and left-align the used bits so the shifter
  // always emits from the MSB regardless of length.
  always_comb begin
    len_clamp = length;
    if (length == '0 || length > FULL_LEN) begin
      len_clamp = FULL_LEN;
    end
    rep_clamp = repeats;
    if (repeats == '0) begin
      rep_clamp = CNT_ONE;
    end
    shift_amt = PAT_W - int'(len_clamp);
    aligned   = pattern << shift_amt;
  end

  // Next-state and next-output logic. Every register holds by default, and
  // the pulses (bit_strobe, done) default low so they last exactly one clock.
  always_comb begin
    state_n    = state_q;
    shreg_n    = shreg_q;
    pat_n      = pat_q;
    len_n      = len_q;
    bit_cnt_n  = bit_cnt_q;
    pass_cnt_n = pass_cnt_q;
    serial_n   = serial_q;
    strobe_n   = 1'b0;
    done_n     = 1'b0;

    if (abort) begin
      // Abort beats start, so abort+start in IDLE stays in IDLE.
      state_n  = IDLE;
      serial_n = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          serial_n = 1'b0;
          if (start) begin
            shreg_n    = aligned;
            pat_n      = aligned;
            len_n      = len_clamp;
            bit_cnt_n  = len_clamp;
            pass_cnt_n = rep_clamp;
            state_n    = SEND;
          end
        end

        SEND: begin
          if (bit_en) begin
            serial_n  = shreg_q[PAT_W-1];
            strobe_n  = 1'b1;
            shreg_n   = shreg_q << 1;
            bit_cnt_n = bit_cnt_q - CNT_ONE;
            // The bit going out now is the last of this pass; it is held for
            // one more bit period by the GAP/DONE tick that follows.
            if (bit_cnt_q == CNT_ONE) begin
              if (pass_cnt_q > CNT_ONE) begin
                pass_cnt_n = pass_cnt_q - CNT_ONE;
                state_n    = GAP;
              end else begin
                state_n = DONE;
              end
            end
          end
        end

        GAP: begin
          if (bit_en) begin
            serial_n  = 1'b0;
            shreg_n   = pat_q;
            bit_cnt_n = len_q;
            state_n   = SEND;
          end
        end

        DONE: begin
          if (bit_en) begin
            serial_n = 1'b0;
            done_n   = 1'b1;
            state_n  = IDLE;
          end
        end

        default: begin
          // Unused encodings recover to IDLE.
          state_n  = IDLE;
          serial_n = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      pat_q      <= '0;
      len_q      <= '0;
      bit_cnt_q  <= '0;
      pass_cnt_q <= '0;
      serial_q   <= 1'b0;
      strobe_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_n;
      shreg_q    <= shreg_n;
      pat_q      <= pat_n;
      len_q      <= len_n;
      bit_cnt_q  <= bit_cnt_n;
      pass_cnt_q <= pass_cnt_n;
      serial_q   <= serial_n;
      strobe_q   <= strobe_n;
      done_q     <= done_n;
    end
  end

  assign serial_out = serial_q;
  assign bit_strobe = strobe_q;
  assign done       = done_q;
  assign busy       = (state_q == SEND) || (state_q == GAP) || (state_q == DONE);
  assign state      = state_q;

endmodule

// File: tb/tb_sequence_generator.sv
// tb/tb_sequence_generator.sv - scoreboard bench for sequence_generator

module tb_sequence_generator;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic       abort;
  logic       bit_en;
  logic [7:0] pattern;
  logic [3:0] length;
  logic [3:0] repeats;
  logic       serial_out;
  logic       bit_strobe;
  logic       busy;
  logic       done;
  logic [2:0] state;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic so;
    logic strobe;
    logic dn;
  } exp_t;

  exp_t sb[$];

  sequence_generator #(.PAT_W(8), .CNT_W(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .bit_en     (bit_en),
    .pattern    (pattern),
    .length     (length),
    .repeats    (repeats),
    .serial_out (serial_out),
    .bit_strobe (bit_strobe),
    .busy       (busy),
    .done       (done),
    .state      (state)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_state"}, 32'(state), 32'd0);
    check_eq({tag, "_so"}, 32'(serial_out), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_done"}, 32'(done), 32'd0);
    check_eq({tag, "_strobe"}, 32'(bit_strobe), 32'd0);
  endtask

  // Runs one transfer from IDLE. Expected bit periods (pattern bits, gaps,
  // final DONE tick) are queued up front and popped on each bit_en edge.
  // abort_at / restart_at / reset_at: strobed-bit count at which to inject
  // that event on the next edge (0 = never).
  task automatic send_and_check(input logic [7:0] pat, input logic [3:0] len,
                                input logic [3:0] rep, input int en_period,
                                input int abort_at, input int restart_at,
                                input int reset_at);
    int   l;
    int   n;
    int   pops;
    int   cyc;
    logic last_so;
    logic en_d;
    exp_t e;

    l = (len == 4'd0 || len > 4'd8) ? 8 : int'(len);
    n = (rep == 4'd0) ? 1 : int'(rep);
    sb.delete();
    for (int p = 0; p < n; p++) begin
      for (int i = l - 1; i >= 0; i--) sb.push_back('{pat[i], 1'b1, 1'b0});
      if (p < n - 1) sb.push_back('{1'b0, 1'b0, 1'b0});
    end
    sb.push_back('{1'b0, 1'b0, 1'b1});

    pattern = pat;
    length  = len;
    repeats = rep;
    start   = 1'b1;
    bit_en  = 1'b0;
    @(posedge clock);
    @(negedge clock);
    start   = 1'b0;
    pattern = 8'($urandom);
    length  = 4'($urandom);
    repeats = 4'($urandom);
    check_eq("accept_busy", 32'(busy), 32'd1);
    check_eq("accept_state", 32'(state), 32'd1);
    check_eq("accept_so", 32'(serial_out), 32'd0);

    pops    = 0;
    cyc     = 0;
    last_so = 1'b0;
    while (sb.size() > 0 && cyc < 1000) begin
      en_d   = ((cyc % en_period) == en_period - 1);
      bit_en = en_d;
      if (abort_at > 0 && pops == abort_at) abort = 1'b1;
      if (reset_at > 0 && pops == reset_at) reset = 1'b1;
      if (restart_at > 0 && pops == restart_at) start = 1'b1;
      @(posedge clock);
      @(negedge clock);
      cyc++;
      start = 1'b0;
      if (abort || reset) begin
        check_idle(abort ? "abort" : "reset");
        abort  = 1'b0;
        reset  = 1'b0;
        bit_en = 1'b1;
        sb.delete();
        @(posedge clock);
        @(negedge clock);
        check_idle("after_cancel");
        return;
      end
      if (en_d) begin
        e = sb.pop_front();
        if (e.strobe) pops++;
        check_eq("so", 32'(serial_out), 32'(e.so));
        check_eq("strobe", 32'(bit_strobe), 32'(e.strobe));
        check_eq("done", 32'(done), 32'(e.dn));
        last_so = e.so;
      end else begin
        check_eq("hold_so", 32'(serial_out), 32'(last_so));
        check_eq("hold_strobe", 32'(bit_strobe), 32'd0);
        check_eq("hold_done", 32'(done), 32'd0);
      end
    end
    if (cyc >= 1000) check_eq("timeout", 32'd0, 32'd1);
    check_eq("end_busy", 32'(busy), 32'd0);
    check_eq("end_state", 32'(state), 32'd0);
    check_eq("end_so", 32'(serial_out), 32'd0);
    bit_en = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check_idle("post_done");
  endtask

  logic so_tab  [8] = '{0, 1, 0, 0, 0, 1, 0, 0};
  logic str_tab [8] = '{0, 1, 1, 0, 0, 1, 1, 0};
  logic dn_tab  [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
  int   st_tab  [8] = '{1, 1, 3, 0, 1, 1, 3, 0};

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    abort   = 1'b0;
    bit_en  = 1'b0;
    pattern = 8'h00;
    length  = 4'd0;
    repeats = 4'd0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_idle("reset");
    reset  = 1'b0;
    bit_en = 1'b1;
    @(posedge clock);
    @(negedge clock);

    send_and_check(8'h0D, 4'd4, 4'd1, 1, 0, 0, 0);
    send_and_check(8'h0F, 4'd4, 4'd2, 1, 0, 0, 0);
    send_and_check(8'hA5, 4'd0, 4'd1, 3, 0, 0, 0);
    send_and_check(8'h5A, 4'd12, 4'd1, 1, 0, 0, 0);
    send_and_check(8'h05, 4'd3, 4'd3, 2, 0, 0, 0);
    send_and_check(8'h3C, 4'd8, 4'd1, 1, 3, 0, 0);
    send_and_check(8'hC6, 4'd8, 4'd1, 1, 0, 0, 0);
    send_and_check(8'h9B, 4'd8, 4'd1, 1, 0, 2, 4);

    // abort and start together in IDLE: no transfer starts
    start   = 1'b1;
    abort   = 1'b1;
    pattern = 8'hFF;
    length  = 4'd8;
    repeats = 4'd1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    abort = 1'b0;
    check_idle("abort_start");

    // start held high: single pass (repeats=0), one IDLE cycle, restart
    pattern = 8'h02;
    length  = 4'd2;
    repeats = 4'd0;
    bit_en  = 1'b1;
    start   = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clock);
      @(negedge clock);
      if (i == 7) start = 1'b0;
      check_eq($sformatf("held_so%0d", i), 32'(serial_out), 32'(so_tab[i]));
      check_eq($sformatf("held_strobe%0d", i), 32'(bit_strobe), 32'(str_tab[i]));
      check_eq($sformatf("held_done%0d", i), 32'(done), 32'(dn_tab[i]));
      check_eq($sformatf("held_state%0d", i), 32'(state), 32'(st_tab[i]));
    end
    @(posedge clock);
    @(negedge clock);
    check_idle("held_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sequence_generator.md
# sequence_generator

Serial bit-pattern transmitter that produces test stimulus for the serial pattern detector. A pattern of 1-8 bits is loaded on `start` and shifted out MSB-first, one bit per `bit_en` tick, optionally repeated with a one-bit idle gap between passes. It sits between the board switches/keys (pattern, length, start) and the detector's serial input `w`, replacing hand-toggled SW[1] entry.

## Interface
- `PAT_W`, default 8: maximum pattern width in bits.
- `CNT_W`, default 4: width of the length and repeat fields.
- `clock` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high; sampled on the rising edge of `clock`.
- `start` in 1: level-sampled request; accepted only in IDLE.
- `abort` in 1: synchronous cancel; returns to IDLE on the next edge.
- `bit_en` in 1: bit-rate tick; tie to 1 for one bit per clock.
- `pattern` in PAT_W: bits to send; the used bits are `pattern[len-1:0]`, sent from bit `len-1` down to bit 0.
- `length` in CNT_W: bit count; a value of 0 or greater than PAT_W is treated as PAT_W.
- `repeats` in CNT_W: number of passes; a value of 0 is treated as 1.
- `serial_out` out 1: registered serial bit; drives the detector's `w`.
- `bit_strobe` out 1: one-clock pulse on each edge where `serial_out` takes a new pattern bit.
- `busy` out 1: high in SEND, GAP and DONE.
- `done` out 1: one-clock pulse when the final pass completes.
- `state` out 3: current state, for LEDR display.

## Operation
- States and encodings: IDLE=3'b000, SEND=3'b001, GAP=3'b010, DONE=3'b011. Any other encoding goes to IDLE on the next edge.
- IDLE
  - `start`=1: latch `pattern` into the shift register; latch the clamped length into `len` and the bit counter, and the clamped repeats into the pass counter; go to SEND.
  - Outputs in IDLE: `serial_out`=0, `bit_strobe`=0.
- SEND, on each edge with `bit_en`=1:
  - `serial_out` ← current pattern bit; `bit_strobe`=1; bit counter decrements.
  - After the bit sent with counter=1: if pass counter > 1, decrement it and go to GAP; otherwise go to DONE.
  - With `bit_en`=0: hold all registers; `bit_strobe`=0.
- GAP, on the next `bit_en` edge: `serial_out` ← 0, `bit_strobe`=0, reload the shift register from the latched pattern and the bit counter from `len`, go to SEND.
- DONE, on the next `bit_en` edge: `serial_out` ← 0, `done` ← 1 for one clock, go to IDLE. The last bit therefore holds a full bit period.
- Inputs `pattern`, `length` and `repeats` are don't-care after acceptance; changing them mid-transfer has no effect.
- `start` while `busy` is ignored and never queued.
- Priority: `reset` > `abort` > normal operation.
  - `abort` in any state: IDLE on the next edge, `serial_out`=0, no `done` pulse.
  - `abort` and `start` together in IDLE: stay in IDLE.
- `start` held high: a new transfer begins on the edge after `done`, giving back-to-back transmissions with one IDLE cycle between them.

## Timing
- Reset values: state=IDLE, `serial_out`=0, `bit_strobe`=0, `busy`=0, `done`=0, all counters 0.
- Reset mid-transfer: the same values on the next edge; the partial pattern is discarded.
- `start` sampled high at edge k: `busy`=1 after edge k.
- With `bit_en`=1, first bit on `serial_out` after edge k+1.
- One pass of L bits:
  - bits valid after edges k+1 .. k+L;
  - last bit held through edge k+L+1;
  - then either GAP (`serial_out`=0 after edge k+L+1) or DONE.
- N passes with `bit_en`=1:
  - total bit periods from first bit to `done` = N·L + (N−1) gap periods;
  - `done` is high for exactly the one cycle after the DONE tick;
  - `busy` falls on that same edge.
- `bit_en` gated: every SEND/GAP/DONE transition waits for a `bit_en` edge; `bit_strobe` never exceeds one pulse per `bit_en` tick.

## Test plan
- Reset, then `bit_en`=1, `pattern`=8'h0D, `length`=4, `repeats`=1, `start` pulse → `serial_out` 1,1,0,1 on four consecutive cycles; 4 `bit_strobe` pulses; then `serial_out`=0, `done` pulse, `busy` 0, state 000.
- `pattern`=8'h0F, `length`=4, `repeats`=2, output looped into the pattern detector → stream 1111 0 1111; detector output asserts in both passes; exactly one `done` pulse.
- `length`=0, `pattern`=8'hA5, `bit_en` high every 3rd clock → 8 bits 1,0,1,0,0,1,0,1; each bit held 3 clocks; one strobe per bit.
- `abort` during the 3rd bit of an 8-bit send → IDLE next edge, `serial_out`=0, no `done`; a subsequent `start` sends the full new pattern.
- `start` re-pulsed mid-send, then `reset` asserted mid-send → second `start` has no effect; reset gives all outputs 0 and state 000 on the next edge.
- `start` held high, `repeats`=0, `length`=2, `pattern`=2'b10 → each transfer sends exactly one pass (1,0), followed by one IDLE cycle, then the transfer restarts.
